mcycle_datapath_mul: RTL and testbench
======================================

MCYCLE_DATAPATH_MUL -- requirements
Module: mcycle_datapath_mul

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath/register width; legal values 32 and 64.
REQ-002 SHALL provide parameter PC_INIT, default 0, PC value on reset.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Adr  output  WIDTH  memory address.
REQ-006 SHALL have port WriteData  output  WIDTH  store data (RD2 register).
REQ-007 SHALL have port ReadData  input  WIDTH  memory read data.
REQ-008 SHALL have port Instr  output  32  instruction register.
REQ-009 SHALL have port ALUFlags  output  4  {N,Z,C,V} of current ALUResult.
REQ-010 SHALL have ports PCWrite, RegWrite, IRWrite, AdrSrc  input  1 each  PC, register-file and IR write enables; address select.
REQ-011 SHALL have ports RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  input  2 each  mux selects.
REQ-012 SHALL have port ALUControl  input  3  ALU operation.
REQ-013 SHALL have port MulStart  input  1  multiply request.
REQ-014 SHALL have ports MulBusy, MulDone  output  1 each  multiplier running; one-cycle completion pulse.

Function
REQ-015 SHALL register: PC (loads Result when PCWrite), IR (loads ReadData[31:0] when IRWrite), Data, A, WriteData, ALUOut (load ReadData, RD1, RD2, ALUResult every cycle).
REQ-016 SHALL drive Adr = AdrSrc ? Result : PC.
REQ-017 SHALL use RA1 = RegSrc[0] ? 15 : Instr[19:16]; RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0]; write address Instr[15:12].
REQ-018 SHALL have 15 general registers R0-R14; a read of R15 returns Result combinationally; writes to R15 are ignored; a same-cycle write and read of a register returns the old value.
REQ-019 SHALL select SrcA: 00 A, 01 PC, 10 ALUOut, 11 zero; SrcB: 00 WriteData, 01 ExtImm, 10 constant 4, 11 zero.
REQ-020 SHALL form ExtImm: 00 zero-extended Instr[7:0]; 01 zero-extended Instr[11:0]; 10 sign-extended Instr[23:0] shifted left 2; 11 zero.
REQ-021 SHALL implement ALUControl: 000 add, 001 sub (SrcA-SrcB), 010 and, 011 or, 100 xor; others behave as add.
REQ-022 SHALL set N = ALUResult msb, Z = ALUResult all zero; add/sub: C = carry out (sub: 1 = no borrow), V = signed overflow; logical ops: C=V=0.
REQ-023 SHALL select Result: 00 ALUOut, 01 Data, 10 ALUResult, 11 Product.
REQ-024 Multiplier FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on MulStart, latching A as multiplicand and WriteData as multiplier.
REQ-025 RUN SHALL perform one shift-add step per cycle for WIDTH cycles, then enter DONE; MulBusy high exactly in RUN.
REQ-026 DONE SHALL last one cycle with MulDone=1, then return to IDLE; MulStart at cycle t gives MulDone at cycle t+WIDTH+1.
REQ-027 Product SHALL be the low WIDTH bits of the unsigned product, held until the next accepted MulStart, and cleared when that MulStart is accepted.
REQ-028 MulStart in RUN or DONE SHALL be ignored; MulStart in IDLE on the same cycle as RegWrite SHALL use the registered A and WriteData.

Reset
REQ-029 Reset assertion SHALL immediately set PC=PC_INIT; IR, Data, A, WriteData, ALUOut and Product to 0; FSM to IDLE; MulBusy=MulDone=0, including mid-multiply.
REQ-030 Register file contents SHALL NOT be reset and SHALL be undefined until written.

Configuration
REQ-031 With macro MCYCLE_DATAPATH_MUL_EN defined, the multiplier of REQ-024..028 SHALL be present.
REQ-032 Without MCYCLE_DATAPATH_MUL_EN, the ports SHALL remain, MulBusy=MulDone=0, MulStart SHALL be ignored, and ResultSrc=11 SHALL yield zero.

Verification
REQ-033 Release reset with PC_INIT=0, drive IRWrite=1, ReadData=0xE2801005, ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1 for one cycle -> Adr=0 before the edge; Instr=0xE2801005 and PC=4 after it.
REQ-034 A=5, WriteData=5, ALUSrcA=00, ALUSrcB=00, ALUControl=001 -> ALUResult=0, ALUFlags=0110.
REQ-035 SrcA=0x7FFFFFFF, SrcB=constant 4, add (WIDTH=32) -> ALUResult=0x80000003, ALUFlags=1001.
REQ-036 RegSrc[0]=1, ResultSrc=10 -> RD1 equals ALUResult in the same cycle; a write to R15 leaves R0-R14 unchanged.
REQ-037 A=7, WriteData=6, MulStart pulse (WIDTH=32) -> MulBusy high for 32 cycles, MulDone at cycle t+33; ResultSrc=11 gives 42; a second MulStart at t+5 is ignored.
REQ-038 Reset asserted at cycle t+10 of a multiply -> MulBusy=0, Product=0, PC=PC_INIT; a later MulStart runs a full multiply.

Source files
------------

// File: rtl/mcycle_datapath_mul.sv
// mcycle_datapath_mul: multicycle datapath (PC, IR, register file, ALU) with an optional
// shift-add multiplier that is present only when MCYCLE_DATAPATH_MUL_EN is defined.
module mcycle_datapath_mul #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] PC_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] WriteData,
  input  logic [WIDTH-1:0] ReadData,
  output logic [31:0]      Instr,
  output logic [3:0]       ALUFlags,
  input  logic             PCWrite,
  input  logic             RegWrite,
  input  logic             IRWrite,
  input  logic             AdrSrc,
  input  logic [1:0]       RegSrc,
  input  logic [1:0]       ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       ResultSrc,
  input  logic [1:0]       ImmSrc,
  input  logic [2:0]       ALUControl,
  input  logic             MulStart,
  output logic             MulBusy,
  output logic             MulDone
);
  logic [WIDTH-1:0] pc_q, data_q, a_q, wd_q, alu_out_q;
  logic [31:0]      ir_q;
  logic [WIDTH-1:0] rf [15];
  logic [WIDTH-1:0] result, rd1, rd2, src_a, src_b, ext_imm, b_op, alu_result, product;
  logic [WIDTH:0]   sum;
  logic [3:0]       ra1, ra2, wa3;
  logic             sub, arith;

  assign ra1 = RegSrc[0] ? 4'd15 : ir_q[19:16];
  assign ra2 = RegSrc[1] ? ir_q[15:12] : ir_q[3:0];
  assign wa3 = ir_q[15:12];
  // R15 is not storage: it reads back the current Result
  assign rd1 = (ra1 == 4'd15) ? result : rf[ra1];
  assign rd2 = (ra2 == 4'd15) ? result : rf[ra2];

  assign ext_imm = (ImmSrc == 2'b00) ? WIDTH'(ir_q[7:0]) :
                   (ImmSrc == 2'b01) ? WIDTH'(ir_q[11:0]) :
                   (ImmSrc == 2'b10) ? {{(WIDTH-26){ir_q[23]}}, ir_q[23:0], 2'b00} : '0;

  assign src_a = (ALUSrcA == 2'b00) ? a_q : (ALUSrcA == 2'b01) ? pc_q :
                 (ALUSrcA == 2'b10) ? alu_out_q : '0;
  assign src_b = (ALUSrcB == 2'b00) ? wd_q : (ALUSrcB == 2'b01) ? ext_imm :
                 (ALUSrcB == 2'b10) ? WIDTH'(4) : '0;

  // subtraction is SrcA + ~SrcB + 1, so carry out means "no borrow"
  assign sub   = ALUControl == 3'b001;
  assign arith = !(ALUControl inside {3'b010, 3'b011, 3'b100});
  assign b_op  = sub ? ~src_b : src_b;
  assign sum   = {1'b0, src_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};

  assign alu_result = (ALUControl == 3'b010) ? src_a & src_b :
                      (ALUControl == 3'b011) ? src_a | src_b :
                      (ALUControl == 3'b100) ? src_a ^ src_b : sum[WIDTH-1:0];

  assign ALUFlags = {alu_result[WIDTH-1], alu_result == '0, arith & sum[WIDTH],
                     arith & (src_a[WIDTH-1] == b_op[WIDTH-1]) & (sum[WIDTH-1] != src_a[WIDTH-1])};

  assign result = (ResultSrc == 2'b00) ? alu_out_q : (ResultSrc == 2'b01) ? data_q :
                  (ResultSrc == 2'b10) ? alu_result : product;

  assign Adr       = AdrSrc ? result : pc_q;
  assign Instr     = ir_q;
  assign WriteData = wd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= PC_INIT;
      ir_q      <= '0;
      data_q    <= '0;
      a_q       <= '0;
      wd_q      <= '0;
      alu_out_q <= '0;
    end else begin
      if (PCWrite) pc_q <= result;
      if (IRWrite) ir_q <= ReadData[31:0];
      data_q    <= ReadData;
      a_q       <= rd1;
      wd_q      <= rd2;
      alu_out_q <= alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (RegWrite && wa3 != 4'd15) rf[wa3] <= result;
  end

`ifdef MCYCLE_DATAPATH_MUL_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_e;
  mul_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    MulBusy  = state_q == RUN;
    MulDone  = state_q == DONE;
    case (state_q)
      IDLE: if (MulStart) begin
        state_d  = RUN;
        cnt_d    = '0;
        mcand_d  = a_q;
        mplier_d = wd_q;
        prod_d   = '0;
      end
      RUN: begin
        prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        state_d  = (cnt_q == CW'(WIDTH-1)) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = prod_q;
`else
  logic unused_mul_start;
  assign unused_mul_start = MulStart;
  assign MulBusy = 1'b0;
  assign MulDone = 1'b0;
  assign product = '0;
`endif
endmodule

// File: tb/tb_mcycle_datapath_mul.sv
// tb_mcycle_datapath_mul: randomized scoreboard bench for mcycle_datapath_mul (WIDTH=32);
// the multiplier checks are compiled in when MCYCLE_DATAPATH_MUL_EN is defined.
module tb_mcycle_datapath_mul;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b0;
  logic [W-1:0] Adr, WriteData, ReadData;
  logic [31:0] Instr;
  logic [3:0] ALUFlags;
  logic PCWrite, RegWrite, IRWrite, AdrSrc, MulStart, MulBusy, MulDone;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;

  mcycle_datapath_mul #(.WIDTH(W), .PC_INIT('0)) dut (
    .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
    .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .MulStart(MulStart), .MulBusy(MulBusy), .MulDone(MulDone)
  );

  always #5 clk = ~clk;

  typedef struct {string name; int sig; logic [31:0] exp;} chk_t;
  typedef struct {logic [31:0] prod; int due;} mul_t;
  chk_t sb_q[$];
  mul_t mul_q[$];
  int tests = 0, fails = 0, cyc = 0;
  logic [31:0] model_rf [15];

  always @(posedge clk) cyc++;

  task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sig_val(int s);
    return s == 0 ? Adr : s == 1 ? {28'h0, ALUFlags} : s == 2 ? Instr :
           s == 3 ? WriteData : s == 4 ? {31'h0, MulBusy} : {31'h0, MulDone};
  endfunction

  task automatic push_chk(string n, int s, logic [31:0] v);
    chk_t e;
    e.name = n; e.sig = s; e.exp = v;
    sb_q.push_back(e);
  endtask

  // monitor: compares whatever the stimulus queued for the current cycle, plus multiplier completions
  always @(negedge clk) begin : monitor
    chk_t e;
    mul_t m;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      compare(e.name, sig_val(e.sig), e.exp);
    end
    if (MulDone) begin
      if (mul_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL mul_unexpected_done: MulDone=1 with no multiply pending (cycle %0d)", cyc);
      end else begin
        m = mul_q.pop_front();
        compare("mul_product", Adr, m.prod);
        compare("mul_done_cycle", cyc, m.due);
      end
    end else if (mul_q.size() > 0 && cyc > mul_q[0].due) begin
      tests++; fails++;
      $display("FAIL mul_timeout: no MulDone by cycle %0d (cycle %0d)", mul_q[0].due, cyc);
      void'(mul_q.pop_front());
    end
  end

  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, b,
                                  output logic [31:0] r, output logic [3:0] f);
    longint sa, sb, sr, lim;
    logic c, v;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    lim = 64'sd2147483647;
    c = 1'b0; v = 1'b0; sr = 0;
    case (op)
      3'd1: begin r = a - b; c = a >= b; sr = sa - sb; v = sr > lim || sr < -lim - 1; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: begin
        r = a + b; c = ({32'h0, a} + {32'h0, b}) > 64'hFFFF_FFFF;
        sr = sa + sb; v = sr > lim || sr < -lim - 1;
      end
    endcase
    f = {r[31], r == 32'h0, c, v};
  endfunction

  function automatic logic [31:0] ref_imm(logic [1:0] src, logic [31:0] w);
    int s;
    s = int'(w[23:0]);
    if (w[23]) s = s - 32'sd16777216;
    return src == 2'd0 ? {24'h0, w[7:0]} : src == 2'd1 ? {20'h0, w[11:0]} :
           src == 2'd2 ? 32'(s * 4) : 32'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_idle();
    PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0; RegSrc = 0; ALUSrcA = 0;
    ALUSrcB = 0; ResultSrc = 0; ImmSrc = 0; ALUControl = 0; MulStart = 0;
  endtask

  task automatic load_ir(logic [31:0] w);
    ReadData = w; IRWrite = 1; step(); IRWrite = 0;
  endtask

  task automatic write_reg(logic [3:0] r, logic [31:0] v);
    ctl_idle();
    load_ir({16'h0, r, 12'h0});
    ReadData = v; step();
    ResultSrc = 2'b01; RegWrite = 1; step();
    RegWrite = 0; ResultSrc = 2'b00;
    if (r != 4'd15) model_rf[r] = v;
  endtask

  task automatic set_ops(logic [3:0] rn, logic [3:0] rm);
    ctl_idle();
    load_ir({12'h0, rn, 12'h0, rm});
    step();
  endtask

  task automatic mul_run(logic [31:0] a, logic [31:0] b, bit inject);
    mul_t m;
    int t, n, busy;
    write_reg(5, a); write_reg(6, b); set_ops(5, 6);
    AdrSrc = 1; ResultSrc = 2'b11;
    t = cyc;
    m.prod = a * b; m.due = t + W + 1;
    mul_q.push_back(m);
    MulStart = 1; step(); MulStart = 0;
    push_chk("mul_clear", 0, 32'h0);
    n = 0; busy = 0;
    while (!MulDone && n < W + 5) begin
      if (MulBusy) busy++;
      MulStart = inject && cyc == t + 5;
      step();
      n++;
    end
    MulStart = 0;
    compare("mul_busy_cycles", busy, W);
    push_chk("mul_busy_in_done", 4, 32'h0);
    step();
    push_chk("mul_hold", 0, a * b);
    push_chk("mul_done_pulse", 5, 32'h0);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, r, w;
    logic [3:0] f;
    logic [2:0] op;
    logic [31:0] specials [4];
    specials[0] = 32'h0; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'h8000_0000; specials[3] = 32'h7FFF_FFFF;
    ctl_idle(); ReadData = 0;
    repeat (2) @(posedge clk);
    #1;
    push_chk("rst_pc", 0, 32'h0);
    push_chk("rst_instr", 2, 32'h0);
    push_chk("rst_wd", 3, 32'h0);
    push_chk("rst_flags", 1, 32'h4);
    push_chk("rst_busy", 4, 32'h0);
    push_chk("rst_done", 5, 32'h0);
    step();
    reset = 1;
    // fetch: IR load and PC+4
    ReadData = 32'hE280_1005; IRWrite = 1; ALUSrcA = 2'b01; ALUSrcB = 2'b10;
    ResultSrc = 2'b10; PCWrite = 1;
    push_chk("fetch_adr", 0, 32'h0);
    step();
    ctl_idle();
    push_chk("fetch_instr", 2, 32'hE280_1005);
    push_chk("fetch_pc", 0, 32'h4);
    step();
    write_reg(1, 5); set_ops(1, 1);
    ALUControl = 3'b001; ResultSrc = 2'b10; AdrSrc = 1;
    push_chk("sub_zero", 0, 32'h0);
    push_chk("sub_zero_flags", 1, 32'h6);
    push_chk("wd_value", 3, 32'h5);
    step();
    write_reg(2, 32'h7FFF_FFFF); set_ops(2, 0);
    ALUSrcB = 2'b10; ResultSrc = 2'b10; AdrSrc = 1;
    push_chk("ovf_result", 0, 32'h8000_0003);
    push_chk("ovf_flags", 1, 32'h9);
    step();
    for (int i = 0; i < 24; i++) begin
      a = i < 4 ? specials[i] : $urandom;
      b = i < 4 ? specials[3 - i] : (i % 5 == 0) ? a : $urandom;
      op = 3'($urandom_range(0, 7));
      write_reg(3, a); write_reg(4, b); set_ops(3, 4);
      ALUControl = op; ResultSrc = 2'b10; AdrSrc = 1;
      ref_alu(op, a, b, r, f);
      push_chk("alu_result", 0, r);
      push_chk("alu_flags", 1, {28'h0, f});
      step();
    end
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      ctl_idle(); load_ir(w);
      ALUSrcA = 2'b11; ALUSrcB = 2'b01; ImmSrc = 2'(i % 4); ResultSrc = 2'b10; AdrSrc = 1;
      push_chk("ext_imm", 0, ref_imm(2'(i % 4), w));
      step();
      ResultSrc = 2'b00;
      push_chk("alu_out_reg", 0, ref_imm(2'(i % 4), w));
      step();
    end
    // R15 read returns Result, captured into A
    ctl_idle(); load_ir(32'h0000_005A);
    RegSrc = 2'b01; ALUSrcA = 2'b11; ALUSrcB = 2'b01; ResultSrc = 2'b10;
    step();
    RegSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b11; AdrSrc = 1;
    push_chk("r15_read", 0, 32'h5A);
    step();
    for (int i = 0; i < 15; i++) write_reg(4'(i), $urandom);
    write_reg(15, 32'hDEAD_BEEF);
    for (int i = 0; i < 15; i++) begin
      set_ops(4'(i), 0);
      ALUSrcB = 2'b11; ResultSrc = 2'b10; AdrSrc = 1;
      push_chk("regfile_read", 0, model_rf[i]);
      step();
    end
`ifdef MCYCLE_DATAPATH_MUL_EN
    mul_run(7, 6, 1);
    for (int i = 0; i < 4; i++) mul_run($urandom, i == 0 ? 32'hFFFF_FFFF : $urandom, i == 1);
    begin
      int t;
      write_reg(5, $urandom); write_reg(6, $urandom); set_ops(5, 6);
      AdrSrc = 1; ResultSrc = 2'b11;
      t = cyc;
      MulStart = 1; step(); MulStart = 0;
      while (cyc < t + 10) step();
      reset = 0;
      #1;
      compare("rst_mid_busy", {31'h0, MulBusy}, 32'h0);
      compare("rst_mid_product", Adr, 32'h0);
      AdrSrc = 0;
      #1;
      compare("rst_mid_pc", Adr, 32'h0);
      step();
      reset = 1;
    end
    mul_run(32'h0001_2345, 32'h0000_1001, 0);
`else
    write_reg(5, 32'h7); write_reg(6, 32'h6); set_ops(5, 6);
    AdrSrc = 1; ResultSrc = 2'b11; MulStart = 1;
    for (int i = 0; i < W + 4; i++) begin
      push_chk("nomul_busy", 4, 32'h0);
      push_chk("nomul_done", 5, 32'h0);
      push_chk("nomul_product", 0, 32'h0);
      step();
      MulStart = i == 3;
    end
    MulStart = 0;
`endif
    for (int i = 0; i < W + 8 && mul_q.size() > 0; i++) step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
